// File: rtl/fpf_rx_dec_21.sv
// Receive-side decoder for the 21-wire FPF TSV bus: captures a word, accumulates its FNS
// weights bit-serially, screens it for 010/101 triplets and returns the result by handshake.
module fpf_rx_dec_21 #(
    parameter int unsigned NW   = 21,
    parameter int unsigned DW   = 15,
    parameter int unsigned DMAX = 28657,
    parameter int unsigned CW   = 16
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [NW-1:0] tsv,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] dataout,
    output logic          fp_err,
    output logic          range_err,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] err_count,
    input  logic          clr_count
);

    localparam int unsigned KW = $clog2(NW);

    // FNS weights of the 21-wire code: wire k carries Fibonacci F(k+1).
    localparam int unsigned FW [21] = '{
        1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610,
        987, 1597, 2584, 4181, 6765, 10946
    };

    typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

    state_e          state_q, state_d;
    logic [NW-1:0]   sreg_q, sreg_d;
    logic [DW:0]     acc_q, acc_d;
    logic [KW-1:0]   k_q, k_d;
    logic            fp_err_r_q, fp_err_r_d;
    logic [DW-1:0]   dataout_q, dataout_d;
    logic            fp_err_q, fp_err_d;
    logic            range_err_q, range_err_d;
    logic            out_valid_q, out_valid_d;
    logic [CW-1:0]   err_count_q, err_count_d;
    logic            err_inc;
    logic            fp_hit;

    always_comb begin
        fp_hit = 1'b0;
        for (int j = 0; j <= int'(NW) - 3; j++) begin
            if (tsv[j+:3] == 3'b101 || tsv[j+:3] == 3'b010) begin
                fp_hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        acc_d       = acc_q;
        k_d         = k_q;
        fp_err_r_d  = fp_err_r_q;
        dataout_d   = dataout_q;
        fp_err_d    = fp_err_q;
        range_err_d = range_err_q;
        out_valid_d = out_valid_q;
        err_inc     = 1'b0;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sreg_d     = tsv;
                    acc_d      = '0;
                    k_d        = KW'(NW - 1);
                    fp_err_r_d = fp_hit;
                    state_d    = StAcc;
                end
            end
            StAcc: begin
                if (sreg_q[k_q]) begin
                    acc_d = acc_q + (DW+1)'(FW[k_q]);
                end
                k_d = k_q - 1'b1;
                if (k_q == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // First DONE cycle loads the output registers; they then hold until accepted.
                if (!out_valid_q) begin
                    dataout_d   = acc_q[DW-1:0];
                    range_err_d = (acc_q >= (DW+1)'(DMAX));
                    fp_err_d    = fp_err_r_q;
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                    err_inc     = fp_err_q | range_err_q;
                end
            end
            default: state_d = StIdle;
        endcase

        err_count_d = err_count_q;
        if (clr_count) begin
            err_count_d = '0;
        end else if (err_inc && (err_count_q != '1)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            sreg_q      <= '0;
            acc_q       <= '0;
            k_q         <= '0;
            fp_err_r_q  <= 1'b0;
            dataout_q   <= '0;
            fp_err_q    <= 1'b0;
            range_err_q <= 1'b0;
            out_valid_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            fp_err_r_q  <= fp_err_r_d;
            dataout_q   <= dataout_d;
            fp_err_q    <= fp_err_d;
            range_err_q <= range_err_d;
            out_valid_q <= out_valid_d;
            err_count_q <= err_count_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign dataout   = dataout_q;
    assign fp_err    = fp_err_q;
    assign range_err = range_err_q;
    assign out_valid = out_valid_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_fpf_rx_dec_21.sv
// Scoreboard bench for fpf_rx_dec_21; a CW=4 copy shares the stimulus to test saturation.
module tb_fpf_rx_dec_21;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [20:0] tsv;
    logic        in_valid, out_ready, clr_count;

    logic        in_ready, fp_err, range_err, out_valid;
    logic [14:0] dataout;
    logic [15:0] err_count;

    logic        in_ready4, fp_err4, range_err4, out_valid4;
    logic [14:0] dataout4;
    logic [3:0]  err_count4;

    typedef struct {
        logic [14:0] d;
        logic        fp;
        logic        rng;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   fw[21];

    always #5 clock = ~clock;

    fpf_rx_dec_21 dut (
        .clock(clock), .reset_n(reset_n), .tsv(tsv), .in_valid(in_valid),
        .in_ready(in_ready), .dataout(dataout), .fp_err(fp_err), .range_err(range_err),
        .out_valid(out_valid), .out_ready(out_ready), .err_count(err_count),
        .clr_count(clr_count)
    );

    fpf_rx_dec_21 #(.CW(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .tsv(tsv), .in_valid(in_valid),
        .in_ready(in_ready4), .dataout(dataout4), .fp_err(fp_err4), .range_err(range_err4),
        .out_valid(out_valid4), .out_ready(out_ready), .err_count(err_count4),
        .clr_count(clr_count)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int fsum(input logic [20:0] w);
        int s = 0;
        for (int i = 0; i < 21; i++) if (w[i]) s += fw[i];
        return s;
    endfunction

    // Random forbidden-pattern-free word: interior runs are at least two bits long.
    function automatic logic [20:0] rand_fpf();
        logic [20:0] w = '0;
        logic        v = 1'($urandom_range(0, 1));
        int          i = 0;
        int          len;
        bit          first = 1'b1;
        while (i < 21) begin
            len = first ? int'($urandom_range(1, 4)) : int'($urandom_range(2, 5));
            for (int j = 0; j < len && i < 21; j++) begin
                w[i] = v;
                i++;
            end
            v = ~v;
            first = 1'b0;
        end
        return w;
    endfunction

    always @(negedge clock) begin : monitor
        exp_t e;
        #1;
        if (reset_n && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got dataout %0d, expected no output", dataout);
            end else begin
                e = sbq.pop_front();
                check("dataout", int'(dataout), int'(e.d));
                check("fp_err", int'(fp_err), int'(e.fp));
                check("range_err", int'(range_err), int'(e.rng));
                check("dataout_cw4", int'(dataout4), int'(e.d));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
    endtask

    task automatic send(input logic [20:0] w, input int exp_d, input bit exp_fp,
                        input bit clr_hs);
        int   n;
        exp_t e;
        wait_ready();
        e.d   = exp_d[14:0];
        e.fp  = exp_fp;
        e.rng = 1'b0;
        sbq.push_back(e);
        tsv      = w;
        in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        tsv      = 21'($urandom);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("latency", n, 22);
        if (clr_hs) begin
            clr_count = 1'b1;
            @(negedge clock);
            clr_count = 1'b0;
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [20:0] w;
        exp_t        e;
        int          n;

        fw[0] = 1;
        fw[1] = 1;
        for (int i = 2; i < 21; i++) fw[i] = fw[i-1] + fw[i-2];

        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_count = 1'b0; tsv = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_dataout", int'(dataout), 0);
        check("rst_fp_err", int'(fp_err), 0);
        check("rst_range_err", int'(range_err), 0);
        check("rst_err_count", int'(err_count), 0);

        // Round trip: zero, 356 (wires 6..11), all-ones = largest legal value 28656.
        send(21'h000000, 0, 1'b0, 1'b0);
        send(21'h000FC0, 356, 1'b0, 1'b0);
        send(21'h1FFFFF, 28656, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) begin
            w = rand_fpf();
            send(w, fsum(w), 1'b0, 1'b0);
        end
        @(negedge clock);
        check("err_count_roundtrip", int'(err_count), 0);

        // Forbidden triplets at the bottom and top windows, plus clean neighbours.
        send(21'h000005, 3, 1'b1, 1'b0);
        send(21'h080000, 6765, 1'b1, 1'b0);
        send(21'h000000, 0, 1'b0, 1'b0);
        send(21'h000003, 2, 1'b0, 1'b0);
        send(21'h140000, 15127, 1'b1, 1'b0);
        @(negedge clock);
        check("err_count_fp", int'(err_count), 3);

        // Back-pressure, with stray in_valid pulses during ACC and DONE.
        out_ready = 1'b0;
        wait_ready();
        e.d = 15'd356; e.fp = 1'b0; e.rng = 1'b0;
        sbq.push_back(e);
        tsv = 21'h000FC0;
        in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            in_valid = (n == 5);
            tsv      = 21'h000005;
            @(negedge clock);
            n++;
        end
        in_valid = 1'b0;
        check("latency_bp", n, 22);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i == 3);
            tsv      = 21'h140000;
            @(negedge clock);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_dataout", int'(dataout), 356);
            check("bp_fp_err", int'(fp_err), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("err_count_bp", int'(err_count), 3);

        // Reset in the middle of ACC.
        wait_ready();
        tsv = 21'h000005;
        in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (9) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_err_count", int'(err_count), 0);
        check("midrst_err_count_cw4", int'(err_count4), 0);
        send(21'h000FC0, 356, 1'b0, 1'b0);

        // Saturation of the 4-bit copy, then clear racing an erroneous handshake.
        for (int i = 0; i < 20; i++) send(21'h000005, 3, 1'b1, 1'b0);
        @(negedge clock);
        check("err_count_20", int'(err_count), 20);
        check("err_count_sat_cw4", int'(err_count4), 15);
        send(21'h000005, 3, 1'b1, 1'b1);
        check("clr_priority", int'(err_count), 0);
        check("clr_priority_cw4", int'(err_count4), 0);

        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        repeat (3) @(negedge clock);
        check("queue_drained", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
